// File: rtl/sr_pulse_driver.sv
// Write sequencer for a bank of SR storage cells with per-bit S/R polarity:
// pulses masked bits, waits one settle cycle, checks readback and tracks a shadow copy.
module sr_pulse_driver #(
  parameter int unsigned      WIDTH     = 3,
  parameter logic [WIDTH-1:0] S_POL     = 3'b111,
  parameter logic [WIDTH-1:0] R_POL     = 3'b011,
  parameter int unsigned      PULSE_CYC = 2,
  parameter logic [WIDTH-1:0] INIT      = 3'b000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [WIDTH-1:0] req_mask,
  output logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] R,
  input  logic [WIDTH-1:0] q_in,
  output logic             done_valid,
  output logic             done_err,
  output logic [WIDTH-1:0] shadow
);

  localparam logic [WIDTH-1:0] SIdle     = ~S_POL;
  localparam logic [WIDTH-1:0] RIdle     = ~R_POL;
  localparam logic [3:0]       PulseLoad = 4'(PULSE_CYC);

  typedef enum logic [1:0] {
    StIdle,
    StPulse,
    StSettle,
    StCheck
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             ready_q, ready_d;
  logic             done_valid_q, done_valid_d;
  logic             done_err_q, done_err_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mask_d       = mask_q;
    target_d     = target_q;
    s_d          = s_q;
    r_d          = r_q;
    ready_d      = ready_q;
    done_valid_d = 1'b0;
    done_err_d   = 1'b0;
    shadow_d     = shadow_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid && ready_q) begin
          mask_d   = req_mask;
          target_d = (shadow_q & ~req_mask) | (req_data & req_mask);
          ready_d  = 1'b0;
          if (|req_mask) begin
            state_d = StPulse;
            cnt_d   = PulseLoad;
            // Logical set/reset vectors folded straight into physical polarity.
            s_d     = (req_mask & req_data) ^ SIdle;
            r_d     = (req_mask & ~req_data) ^ RIdle;
          end else begin
            state_d      = StCheck;
            done_valid_d = 1'b1;
          end
        end
      end
      StPulse: begin
        // Counter saturates at the exit condition rather than wrapping.
        if (cnt_q <= 4'd1) begin
          state_d = StSettle;
          cnt_d   = 4'd0;
          s_d     = SIdle;
          r_d     = RIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StSettle: begin
        state_d      = StCheck;
        done_valid_d = 1'b1;
        done_err_d   = |((q_in ^ target_q) & mask_q);
      end
      StCheck: begin
        state_d  = StIdle;
        shadow_d = target_q;
        ready_d  = 1'b1;
      end
      default: begin
        state_d = StIdle;
        s_d     = SIdle;
        r_d     = RIdle;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      mask_q       <= '0;
      target_q     <= INIT;
      s_q          <= SIdle;
      r_q          <= RIdle;
      ready_q      <= 1'b1;
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
      shadow_q     <= INIT;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      target_q     <= target_d;
      s_q          <= s_d;
      r_q          <= r_d;
      ready_q      <= ready_d;
      done_valid_q <= done_valid_d;
      done_err_q   <= done_err_d;
      shadow_q     <= shadow_d;
    end
  end

  assign S          = s_q;
  assign R          = r_q;
  assign req_ready  = ready_q;
  assign done_valid = done_valid_q;
  assign done_err   = done_err_q;
  assign shadow     = shadow_q;

`ifndef SYNTHESIS
  a_no_s_r_overlap : assert property (@(posedge clk) disable iff (rst)
    ((s_q ^ SIdle) & (r_q ^ RIdle)) == '0);
  a_done_one_cycle : assert property (@(posedge clk) disable iff (rst)
    done_valid_q |=> !done_valid_q);
`endif

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Scoreboard bench for sr_pulse_driver: behavioural SR cell bank plus per-write expectations.
module tb_sr_pulse_driver;

  localparam int unsigned W    = 3;
  localparam logic [2:0]  SPOL = 3'b111;
  localparam logic [2:0]  RPOL = 3'b011;
  localparam int unsigned PCYC = 2;
  localparam logic [2:0]  INIT = 3'b000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_data = '0;
  logic [2:0] req_mask = '0;
  logic [2:0] S, R;
  logic [2:0] q_in;
  logic       done_valid, done_err;
  logic [2:0] shadow;

  logic       stuck = 1'b0;
  logic [2:0] cells = INIT;
  logic [2:0] sh_model = INIT;

  typedef struct {
    logic [2:0] target;
    logic       err;
    int         lat;
  } exp_t;
  exp_t sb[$];

  int tests_run = 0;
  int tests_failed = 0;

  sr_pulse_driver #(
    .WIDTH    (W),
    .S_POL    (SPOL),
    .R_POL    (RPOL),
    .PULSE_CYC(PCYC),
    .INIT     (INIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_mask  (req_mask),
    .S         (S),
    .R         (R),
    .q_in      (q_in),
    .done_valid(done_valid),
    .done_err  (done_err),
    .shadow    (shadow)
  );

  always #5 clk = ~clk;

  // Behavioural SR cells: logical strobes recovered from physical polarity.
  always @(posedge clk) cells <= (cells | (S ^ ~SPOL)) & ~(R ^ ~RPOL);
  assign q_in = stuck ? 3'b000 : cells;

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (S !== 3'b000) begin tests_failed++; $display("FAIL reset_S got %b want 000", S); end
    tests_run++;
    if (R !== 3'b100) begin tests_failed++; $display("FAIL reset_R got %b want 100", R); end
    tests_run++;
    if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b", req_ready); end
    tests_run++;
    if (shadow !== INIT) begin tests_failed++; $display("FAIL reset_shadow got %b", shadow); end
    tests_run++;
    if (done_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b", done_valid); end
    @(negedge clk);
    rst = 1'b0;
    sh_model = INIT;
  endtask

  task automatic test_write(input logic [2:0] data, input logic [2:0] mask,
                            input bit stuck_i, input string name);
    exp_t e, got_e;
    logic [2:0] exp_s, exp_r;
    bit got;
    @(negedge clk);
    stuck     = stuck_i;
    req_data  = data;
    req_mask  = mask;
    req_valid = 1'b1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_ready_idle got %b want 1", name, req_ready);
    end
    e.target = (sh_model & ~mask) | (data & mask);
    e.err    = |(((stuck_i ? 3'b000 : ((cells & ~mask) | (data & mask))) ^ e.target) & mask);
    e.lat    = (mask != 3'b000) ? PCYC + 2 : 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    got = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      if (mask != 3'b000 && k <= PCYC) begin
        exp_s = (mask & data) ^ ~SPOL;
        exp_r = (mask & ~data) ^ ~RPOL;
      end else begin
        exp_s = ~SPOL;
        exp_r = ~RPOL;
      end
      tests_run++;
      if (S !== exp_s || R !== exp_r) begin
        tests_failed++;
        $display("FAIL %s_strobe cyc %0d got S=%b R=%b want S=%b R=%b",
                 name, k, S, R, exp_s, exp_r);
      end
      if (done_valid === 1'b1) begin
        got   = 1'b1;
        got_e = sb.pop_front();
        tests_run++;
        if (k != got_e.lat) begin
          tests_failed++;
          $display("FAIL %s_latency got %0d want %0d", name, k, got_e.lat);
        end
        tests_run++;
        if (done_err !== got_e.err) begin
          tests_failed++;
          $display("FAIL %s_err got %b want %b", name, done_err, got_e.err);
        end
        sh_model = got_e.target;
      end else if (req_ready !== 1'b0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL %s_ready_busy cyc %0d got %b want 0", name, k, req_ready);
      end
      if (!got) begin
        @(posedge clk);
        #1;
      end
    end
    if (!got) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s_timeout got no done_valid want one", name);
      void'(sb.pop_front());
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (shadow !== sh_model) begin
      tests_failed++;
      $display("FAIL %s_shadow got %b want %b", name, shadow, sh_model);
    end
    tests_run++;
    if (done_valid !== 1'b0 || req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_after got done=%b ready=%b want 0 1", name, done_valid, req_ready);
    end
    stuck = 1'b0;
  endtask

  task automatic test_abort();
    bit seen_done = 1'b0;
    @(negedge clk);
    req_data  = 3'b011;
    req_mask  = 3'b011;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    tests_run++;
    if (S !== 3'b011) begin tests_failed++; $display("FAIL abort_pulse_S got %b want 011", S); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (S !== 3'b000 || R !== 3'b100) begin
      tests_failed++;
      $display("FAIL abort_strobes got S=%b R=%b want S=000 R=100", S, R);
    end
    tests_run++;
    if (shadow !== INIT || req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_state got shadow=%b ready=%b want %b 1", shadow, req_ready, INIT);
    end
    @(negedge clk);
    rst = 1'b0;
    sh_model = INIT;
    for (int k = 0; k < 8; k++) begin
      if (done_valid === 1'b1) seen_done = 1'b1;
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (seen_done) begin tests_failed++; $display("FAIL abort_no_done got done_valid=1 want 0"); end
  endtask

  initial begin
    test_reset();
    test_write(3'b101, 3'b111, 1'b0, "full_write");
    test_write(3'b010, 3'b010, 1'b0, "partial_write");
    test_write(3'b110, 3'b000, 1'b0, "empty_mask");
    test_write(3'b001, 3'b001, 1'b1, "stuck_readback");
    test_abort();
    test_write(3'b110, 3'b101, 1'b0, "post_abort");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
